nios_debug_vjtag_host: RTL and testbench

//  Virtual-JTAG initiator driving the CPU debug slave's vji_* port (ir_in, tck, tdi, uir/cdr/sdr/udr/rti; tdo, ir_out back).

---
 rtl/nios_debug_vjtag_host.sv | 144 ++++++++++++++
 tb/tb_nios_debug_vjtag_host.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_vjtag_host.sv
// Virtual-JTAG initiator: runs one {IR, DR} command as UIR -> CDR -> SDR x DR_WIDTH -> UDR on the vji_* port.
// Optional feature: define JTAG_LOOPBACK_EN to add cfg_loopback (sampled tdo replaced by vj_tdi).
module nios_debug_vjtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  input  logic                cmd_ir_only,
`ifdef JTAG_LOOPBACK_EN
  input  logic                cfg_loopback,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [IR_WIDTH-1:0] vj_ir_in,
  input  logic [IR_WIDTH-1:0] vj_ir_out,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr,
  output logic                vj_rti
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic                ir_only_q;
  logic                active, tick, rise, fall, accept, rsp_done, tdo_bit;

`ifdef JTAG_LOOPBACK_EN
  logic loop_q;
  assign tdo_bit = loop_q ? vj_tdi : vj_tdo;
`else
  assign tdo_bit = vj_tdo;
`endif

  always_comb begin
    state_d  = state_q;
    active   = (state_q inside {S_UIR, S_CDR, S_SDR, S_UDR});
    tick     = active && (div_q == DIV_LAST);
    rise     = tick && !vj_tck;
    fall     = tick && vj_tck;
    accept   = (state_q == S_IDLE) && cmd_valid;
    rsp_done = (state_q == S_RSP) && rsp_valid && rsp_ready;
    case (state_q)
      S_IDLE: if (accept) state_d = S_UIR;
      S_UIR:  if (fall) state_d = ir_only_q ? S_RSP : S_CDR;
      S_CDR:  if (fall) state_d = S_SDR;
      S_SDR:  if (fall && (bit_cnt_q == CNT_LAST)) state_d = S_UDR;
      S_UDR:  if (fall) state_d = S_RSP;
      S_RSP:  if (rsp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ir_only_q <= 1'b0;
`ifdef JTAG_LOOPBACK_EN
      loop_q    <= 1'b0;
`endif
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ir    <= '0;
      vj_tck    <= 1'b0;
      vj_tdi    <= 1'b0;
      vj_ir_in  <= '0;
      vj_uir    <= 1'b0;
      vj_cdr    <= 1'b0;
      vj_sdr    <= 1'b0;
      vj_udr    <= 1'b0;
      vj_rti    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == S_IDLE);
      vj_rti    <= (state_d == S_IDLE) || (state_d == S_RSP);
      vj_uir    <= (state_d == S_UIR);
      vj_cdr    <= (state_d == S_CDR);
      vj_sdr    <= (state_d == S_SDR);
      vj_udr    <= (state_d == S_UDR);

      // tck is held low outside the shift phases; each half-period is TCK_DIV clk long.
      if (!active) begin
        div_q  <= '0;
        vj_tck <= 1'b0;
      end else if (tick) begin
        div_q  <= '0;
        vj_tck <= ~vj_tck;
      end else begin
        div_q <= div_q + 1'b1;
      end

      if (accept) begin
        shift_q   <= cmd_data;
        ir_only_q <= cmd_ir_only;
        vj_ir_in  <= cmd_ir;
        bit_cnt_q <= '0;
`ifdef JTAG_LOOPBACK_EN
        loop_q    <= cfg_loopback;
`endif
      end

      if ((state_q == S_UIR) && rise) rsp_ir <= vj_ir_out;
      if ((state_q == S_UIR) && fall && !ir_only_q) vj_tdi <= shift_q[0];

      // The rise captures tdo into the MSB; the following fall presents the next data bit.
      if (state_q == S_SDR) begin
        if (rise) shift_q <= {tdo_bit, shift_q[DR_WIDTH-1:1]};
        if (fall) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          vj_tdi    <= (bit_cnt_q == CNT_LAST) ? 1'b0 : shift_q[0];
        end
      end

      rsp_valid <= (state_q == S_RSP) && !rsp_done;
      if ((state_q == S_RSP) && !rsp_valid) rsp_data <= shift_q;
    end
  end

endmodule

// File: tb/tb_nios_debug_vjtag_host.sv
// Self-checking bench for nios_debug_vjtag_host: behavioural slave shift register plus a transaction-level model.
module tb_nios_debug_vjtag_host;

  localparam int DR      = 38;
  localparam int IRW     = 2;
  localparam int TCK_DIV = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DR-1:0]  cmd_data = '0;
  logic           cmd_ir_only = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DR-1:0]  rsp_data;
  logic [IRW-1:0] rsp_ir;
  logic           vj_tck, vj_tdi, vj_tdo;
  logic [IRW-1:0] vj_ir_in;
  logic [IRW-1:0] vj_ir_out = '0;
  logic           vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;
`ifdef JTAG_LOOPBACK_EN
  logic           cfg_loopback = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [DR-1:0] slave_sr = '0;
  int uir_cyc, cdr_cyc, sdr_cyc, udr_cyc, flag_err;

  nios_debug_vjtag_host #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(TCK_DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .cmd_ir_only(cmd_ir_only),
`ifdef JTAG_LOOPBACK_EN
    .cfg_loopback(cfg_loopback),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir(rsp_ir),
    .vj_tck(vj_tck), .vj_tdi(vj_tdi), .vj_tdo(vj_tdo),
    .vj_ir_in(vj_ir_in), .vj_ir_out(vj_ir_out),
    .vj_uir(vj_uir), .vj_cdr(vj_cdr), .vj_sdr(vj_sdr), .vj_udr(vj_udr), .vj_rti(vj_rti)
  );

  always #5 clk = ~clk;

  // Slave: a plain DR shift register clocked by tck while in SDR, LSB out on tdo.
  assign vj_tdo = slave_sr[0];
  always @(posedge vj_tck) if (vj_sdr) slave_sr <= {vj_tdi, slave_sr[DR-1:1]};

  // Virtual state monitor: exactly one of uir/cdr/sdr/udr/rti, and tck low whenever rti.
  always @(negedge clk) if (!reset) begin
    if ((int'(vj_uir) + int'(vj_cdr) + int'(vj_sdr) + int'(vj_udr) + int'(vj_rti)) != 1) flag_err++;
    if (vj_rti && vj_tck) flag_err++;
    if (vj_uir) uir_cyc++;
    if (vj_cdr) cdr_cyc++;
    if (vj_sdr) sdr_cyc++;
    if (vj_udr) udr_cyc++;
  end

  task automatic issue(input logic [IRW-1:0] ir, input logic [DR-1:0] data, input bit ir_only);
    @(negedge clk);
    cmd_ir = ir; cmd_data = data; cmd_ir_only = ir_only; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Returns cycles from the accept edge to the first edge showing rsp_valid (0 on timeout).
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin lat = i; break; end
    end
  endtask

  task automatic consume();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL handshake rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic run_and_check(input string name, input logic [IRW-1:0] ir, input logic [DR-1:0] data,
                               input bit ir_only, input logic [DR-1:0] preload,
                               input logic [IRW-1:0] irout, input bit lb);
    int exp_lat, lat, per;
    logic [DR-1:0] exp_data, exp_sr;
    per      = 2 * TCK_DIV;
    exp_lat  = 1 + (ir_only ? 1 : DR + 3) * per;
    exp_data = ir_only ? data : (lb ? data : preload);
    exp_sr   = ir_only ? preload : data;
    slave_sr = preload; vj_ir_out = irout;
    uir_cyc = 0; cdr_cyc = 0; sdr_cyc = 0; udr_cyc = 0; flag_err = 0;
`ifdef JTAG_LOOPBACK_EN
    cfg_loopback = lb;
`endif
    issue(ir, data, ir_only);
    wait_rsp(lat);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat); end
    checks++;
    if (rsp_data !== exp_data) begin errors++; $display("FAIL %s rsp_data got=%h want=%h", name, rsp_data, exp_data); end
    checks++;
    if (rsp_ir !== irout) begin errors++; $display("FAIL %s rsp_ir got=%b want=%b", name, rsp_ir, irout); end
    checks++;
    if (vj_ir_in !== ir) begin errors++; $display("FAIL %s vj_ir_in got=%b want=%b", name, vj_ir_in, ir); end
    checks++;
    if (slave_sr !== exp_sr) begin errors++; $display("FAIL %s slave_tdi got=%h want=%h", name, slave_sr, exp_sr); end
    checks++;
    if (uir_cyc !== per || cdr_cyc !== (ir_only ? 0 : per) || sdr_cyc !== (ir_only ? 0 : DR * per)
        || udr_cyc !== (ir_only ? 0 : per)) begin
      errors++;
      $display("FAIL %s phase_cycles got uir=%0d cdr=%0d sdr=%0d udr=%0d", name, uir_cyc, cdr_cyc, sdr_cyc, udr_cyc);
    end
    checks++;
    if (flag_err !== 0) begin errors++; $display("FAIL %s flag_onehot got=%0d violations want=0", name, flag_err); end
    consume();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, rsp_valid} !== 7'b0 || vj_rti !== 1'b1
        || rsp_data !== '0 || rsp_ir !== '0 || vj_ir_in !== '0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_values tck=%b tdi=%b rti=%b rsp_valid=%b cmd_ready=%b", vj_tck, vj_tdi,
                         vj_rti, rsp_valid, cmd_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_full();
    run_and_check("full", 2'b01, 38'h2A55555555, 1'b0, 38'h0F000000FF, 2'b01, 1'b0);
  endtask

  task automatic test_ir_only();
    run_and_check("ir_only", 2'b11, 38'h1234567890, 1'b1, 38'h3, 2'b10, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [63:0] a, b;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      run_and_check("random", IRW'($urandom_range(3)), a[DR-1:0], ($urandom_range(2) == 0),
                    b[DR-1:0], IRW'($urandom_range(3)), 1'b0);
    end
  endtask

  task automatic test_hold();
    int lat, bad;
    logic [DR-1:0] pre;
    pre = 38'h2BADC0FFEE;
    slave_sr = pre; vj_ir_out = 2'b01;
    issue(2'b10, 38'h0011223344, 1'b0);
    wait_rsp(lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_ir = 2'b11; cmd_data = 38'h3F; cmd_valid = (i == 5) || (i >= 10 && i < 13);
      if (rsp_valid !== 1'b1 || rsp_data !== pre || cmd_ready !== 1'b0 || vj_uir !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_stable got=%0d bad cycles want=0 (data=%h)", bad, rsp_data); end
    // Response completion and a new command offered together.
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_data = 38'h155; cmd_ir_only = 1'b1;
    vj_ir_out = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || vj_uir !== 1'b0) begin
      errors++; $display("FAIL same_cycle rsp_valid=%b cmd_ready=%b uir=%b want 0/1/0", rsp_valid, cmd_ready, vj_uir);
    end
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (vj_uir !== 1'b1 || vj_ir_in !== 2'b01) begin
      errors++; $display("FAIL next_accept uir=%b ir_in=%b want 1/01", vj_uir, vj_ir_in);
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 1 + 2 * TCK_DIV || rsp_ir !== 2'b11) begin
      errors++; $display("FAIL next_rsp latency=%0d rsp_ir=%b want %0d/11", lat, rsp_ir, 1 + 2 * TCK_DIV);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    int rises;
    logic prev;
    slave_sr = 38'h1; vj_ir_out = 2'b00;
    issue(2'b01, 38'h3C3C3C3C3C, 1'b0);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 400 && rises < 17; i++) begin
      @(posedge clk); #1;
      if (vj_sdr && vj_tck && !prev) rises++;
      prev = vj_tck;
    end
    checks++;
    if (rises !== 17) begin errors++; $display("FAIL mid_reset sdr_rises got=%0d want=17", rises); end
    reset = 1'b1;
    #1;
    checks++;
    if ({vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, rsp_valid} !== 7'b0 || vj_rti !== 1'b1
        || cmd_ready !== 1'b1 || rsp_data !== '0) begin
      errors++; $display("FAIL mid_reset_outputs tck=%b tdi=%b sdr=%b rti=%b cmd_ready=%b", vj_tck, vj_tdi,
                         vj_sdr, vj_rti, cmd_ready);
    end
    @(negedge clk); reset = 1'b0;
    run_and_check("after_reset", 2'b10, 38'h0A5A5A5A5A, 1'b0, 38'h3123456789, 2'b01, 1'b0);
  endtask

`ifdef JTAG_LOOPBACK_EN
  task automatic test_loopback();
    run_and_check("loopback", 2'b01, 38'h3FFFFF0000, 1'b0, 38'h0000ABCDEF, 2'b00, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_ir_only();
    test_hold();
    test_mid_reset();
    test_random();
`ifdef JTAG_LOOPBACK_EN
    test_loopback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
